// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the default data width, register-address width, the write-port
// source select encoding and the x0 request filter.
package regfile_wr_arbiter_pkg;

    localparam int RV_XLEN = 32;
    localparam int REG_AW  = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Which source drives the register-file write port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_EX     = 2'd1,
        SEL_FIFO   = 2'd2,
        SEL_BYPASS = 2'd3
    } wb_sel_e;

    // A write to x0 is architecturally a no-op, so it is not a request at all.
    function automatic logic wr_valid(input logic wr, input reg_addr_t addr);
        return wr && (addr != '0);
    endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Purpose: in-order buffer for load writebacks that lost the write port.
// Latency: head visible the cycle after push; pop takes effect on the next edge.
// Backpressure: full flag only; the caller must not push when full or pop when empty.
// Ports: clk_i/reset_i (sync, active-high), en (state update enable),
//        push/wr_dat, pop, head_dat, level, full, empty.
module regwb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = en && push && !full;
    assign do_pop   = en && pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset: entries are only read once level says valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Purpose: shares the register-file write port between EX writeback (always wins) and LSQ load writeback.
// Latency: rf_* is combinational, zero cycles; a blocked load commits the first EX-free cycle it is at the head.
// Backpressure: lsq_ready_o low when the buffer is full (no ready-through-pop); exs_hold_o asks EX to yield.
// Ports: clk_i, reset_i (sync, active-high), clk_en_i; exs_* EX request; lsq_* load request/ready;
//        rf_* write port; rf_src_lsq_o load-commit marker; exs_hold_o; fifo_level_o; lsq_ovf_o (sticky).
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4,
    parameter int XLEN       = RV_XLEN
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clk_en_i,
    input  logic                         exs_wr_i,
    input  logic [REG_AW-1:0]            exs_addr_i,
    input  logic [XLEN-1:0]              exs_data_i,
    input  logic                         lsq_wr_i,
    input  logic [REG_AW-1:0]            lsq_addr_i,
    input  logic [XLEN-1:0]              lsq_data_i,
    output logic                         lsq_ready_o,
    output logic                         rf_wr_o,
    output logic [REG_AW-1:0]            rf_addr_o,
    output logic [XLEN-1:0]              rf_data_o,
    output logic                         rf_src_lsq_o,
    output logic                         exs_hold_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o,
    output logic                         lsq_ovf_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_ent_t;

    logic    ex_req;
    logic    lsq_req;
    wb_sel_e sel;
    wb_ent_t lsq_ent;
    wb_ent_t head_ent;
    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_nxt;

    assign ex_req  = wr_valid(exs_wr_i, exs_addr_i);
    assign lsq_req = wr_valid(lsq_wr_i, lsq_addr_i);
    assign lsq_ent = '{addr: lsq_addr_i, data: lsq_data_i};

    assign lsq_ready_o = !fifo_full;

    // Priority: EX, then the oldest buffered load, then a bypassing load.
    // Bypass only happens with an empty buffer, which is never full, so it
    // needs no ready qualification.
    always_comb begin
        sel = SEL_NONE;
        if (ex_req) begin
            sel = SEL_EX;
        end else if (!fifo_empty) begin
            sel = SEL_FIFO;
        end else if (lsq_req) begin
            sel = SEL_BYPASS;
        end
    end

    always_comb begin
        rf_wr_o      = 1'b0;
        rf_addr_o    = '0;
        rf_data_o    = '0;
        rf_src_lsq_o = 1'b0;
        case (sel)
            SEL_EX: begin
                rf_wr_o   = 1'b1;
                rf_addr_o = exs_addr_i;
                rf_data_o = exs_data_i;
            end
            SEL_FIFO: begin
                rf_wr_o      = 1'b1;
                rf_addr_o    = head_ent.addr;
                rf_data_o    = head_ent.data;
                rf_src_lsq_o = 1'b1;
            end
            SEL_BYPASS: begin
                rf_wr_o      = 1'b1;
                rf_addr_o    = lsq_addr_i;
                rf_data_o    = lsq_data_i;
                rf_src_lsq_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Any accepted load that did not go straight through gets buffered.
    assign fifo_pop  = (sel == SEL_FIFO);
    assign fifo_push = lsq_req && lsq_ready_o && (sel != SEL_BYPASS);

    regwb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_ent_t))
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en       (clk_en_i),
        .push     (fifo_push),
        .wr_dat   (lsq_ent),
        .pop      (fifo_pop),
        .head_dat (head_ent),
        .level    (fifo_level_o),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Counts EX writes that block a waiting load; any pop restarts it.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (fifo_pop) begin
            starve_cnt_nxt = '0;
        end else if (ex_req && !fifo_empty && (starve_cnt != CNT_MAX)) begin
            starve_cnt_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt <= '0;
            exs_hold_o <= 1'b0;
            lsq_ovf_o  <= 1'b0;
        end else if (clk_en_i) begin
            starve_cnt <= starve_cnt_nxt;
            if (fifo_pop) begin
                exs_hold_o <= 1'b0;
            end else if (starve_cnt_nxt == CNT_MAX) begin
                exs_hold_o <= 1'b1;
            end
            // A load offered while full is lost; remember it until reset.
            if (lsq_req && !lsq_ready_o) begin
                lsq_ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic        exs_wr_i;
    logic [4:0]  exs_addr_i;
    logic [31:0] exs_data_i;
    logic        lsq_wr_i;
    logic [4:0]  lsq_addr_i;
    logic [31:0] lsq_data_i;
    logic        lsq_ready_o;
    logic        rf_wr_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        rf_src_lsq_o;
    logic        exs_hold_o;
    logic [1:0]  fifo_level_o;
    logic        lsq_ovf_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Expected commits in order: {addr, data, src_lsq}.
    logic [37:0] exp_q [$];

    regfile_wr_arbiter #(.DEPTH(2), .STARVE_MAX(4), .XLEN(32)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clk_en_i     (clk_en_i),
        .exs_wr_i     (exs_wr_i),
        .exs_addr_i   (exs_addr_i),
        .exs_data_i   (exs_data_i),
        .lsq_wr_i     (lsq_wr_i),
        .lsq_addr_i   (lsq_addr_i),
        .lsq_data_i   (lsq_data_i),
        .lsq_ready_o  (lsq_ready_o),
        .rf_wr_o      (rf_wr_o),
        .rf_addr_o    (rf_addr_o),
        .rf_data_o    (rf_data_o),
        .rf_src_lsq_o (rf_src_lsq_o),
        .exs_hold_o   (exs_hold_o),
        .fifo_level_o (fifo_level_o),
        .lsq_ovf_o    (lsq_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
    endtask

    // Monitor: every enabled commit must match the next scoreboard entry.
    always @(negedge clk_i) begin
        if (!reset_i && clk_en_i && rf_wr_o) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL commit: got unexpected write x%0d=%h src_lsq %b, required no write at %0t",
                         rf_addr_o, rf_data_o, rf_src_lsq_o, $time);
            end else begin
                chk("commit", {26'd0, rf_addr_o, rf_data_o, rf_src_lsq_o}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    // One cycle of stimulus; xw/xa/xd/xs is the commit expected this cycle,
    // lvl/rdy/hold/ovf the status visible during this cycle.
    task automatic step(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                        input logic lw, input logic [4:0] la, input logic [31:0] ld,
                        input logic xw, input logic [4:0] xa, input logic [31:0] xd, input logic xs,
                        input int lvl, input logic rdy, input logic hold, input logic ovf);
        exs_wr_i = ew; exs_addr_i = ea; exs_data_i = ed;
        lsq_wr_i = lw; lsq_addr_i = la; lsq_data_i = ld;
        if (xw) exp_q.push_back({xa, xd, xs});
        @(negedge clk_i);
        chk("level", 64'(fifo_level_o), 64'(lvl));
        chk("lsq_ready", 64'(lsq_ready_o), 64'(rdy));
        chk("exs_hold", 64'(exs_hold_o), 64'(hold));
        chk("lsq_ovf", 64'(lsq_ovf_o), 64'(ovf));
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int lvl, input logic rdy, input logic hold, input logic ovf);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, lvl, rdy, hold, ovf);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        exs_wr_i = 0; exs_addr_i = 0; exs_data_i = 0;
        lsq_wr_i = 0; lsq_addr_i = 0; lsq_data_i = 0;
        @(posedge clk_i); @(posedge clk_i);
        @(negedge clk_i);
        chk("reset rf_wr", 64'(rf_wr_o), 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; clk_en_i = 1'b1;
        exs_wr_i = 0; exs_addr_i = 0; exs_data_i = 0;
        lsq_wr_i = 0; lsq_addr_i = 0; lsq_data_i = 0;
        @(posedge clk_i); #1;
        do_reset();
        idle(0, 1, 0, 0);

        // Bypass with empty buffer
        step(0, 0, 0,  1, 5, 32'hA5,  1, 5, 32'hA5, 1,  0, 1, 0, 0);
        idle(0, 1, 0, 0);

        // Collision and ordering
        step(1, 3, 32'h33,  1, 7, 32'h77,  1, 3, 32'h33, 0,  0, 1, 0, 0);
        step(1, 4, 32'h44,  1, 8, 32'h88,  1, 4, 32'h44, 0,  1, 1, 0, 0);
        step(0, 0, 0,       0, 0, 0,       1, 7, 32'h77, 1,  2, 0, 0, 0);
        step(0, 0, 0,       0, 0, 0,       1, 8, 32'h88, 1,  1, 1, 0, 0);
        idle(0, 1, 0, 0);

        // Overflow: x9 offered while full is dropped
        step(1, 1, 32'h11,  1, 10, 32'hA0,  1, 1, 32'h11, 0,  0, 1, 0, 0);
        step(1, 2, 32'h12,  1, 11, 32'hB0,  1, 2, 32'h12, 0,  1, 1, 0, 0);
        step(1, 1, 32'h13,  1, 9,  32'h99,  1, 1, 32'h13, 0,  2, 0, 0, 0);
        step(0, 0, 0,       0, 0,  0,       1, 10, 32'hA0, 1, 2, 0, 0, 1);
        step(0, 0, 0,       0, 0,  0,       1, 11, 32'hB0, 1, 1, 1, 0, 1);
        idle(0, 1, 0, 1);
        idle(0, 1, 0, 1);
        do_reset();
        idle(0, 1, 0, 0);

        // Starvation: hold after 4 blocking EX writes, saturates, clears with pop
        step(1, 3, 32'h31,  1, 12, 32'hC0,  1, 3, 32'h31, 0,  0, 1, 0, 0);
        step(1, 3, 32'h32,  0, 0,  0,       1, 3, 32'h32, 0,  1, 1, 0, 0);
        step(1, 3, 32'h33,  0, 0,  0,       1, 3, 32'h33, 0,  1, 1, 0, 0);
        step(1, 3, 32'h34,  0, 0,  0,       1, 3, 32'h34, 0,  1, 1, 0, 0);
        step(1, 3, 32'h35,  0, 0,  0,       1, 3, 32'h35, 0,  1, 1, 0, 0);
        step(1, 3, 32'h36,  0, 0,  0,       1, 3, 32'h36, 0,  1, 1, 1, 0);
        step(0, 0, 0,       0, 0,  0,       1, 12, 32'hC0, 1, 1, 1, 1, 0);
        idle(0, 1, 0, 0);

        // x0 filtering
        step(1, 6, 32'h61,  1, 0, 32'hFF,   1, 6, 32'h61, 0,  0, 1, 0, 0);
        step(0, 0, 0,       1, 0, 32'hFE,   0, 0, 0, 0,       0, 1, 0, 0);
        step(1, 0, 32'h01,  1, 13, 32'hD0,  1, 13, 32'hD0, 1, 0, 1, 0, 0);
        idle(0, 1, 0, 0);

        // clk_en low: nothing pushed, nothing popped
        step(1, 3, 32'h3A,  1, 14, 32'hE0,  1, 3, 32'h3A, 0,  0, 1, 0, 0);
        clk_en_i = 1'b0;
        idle(1, 1, 0, 0);
        step(1, 3, 32'h3B,  1, 7, 32'h77,   0, 0, 0, 0,       1, 1, 0, 0);
        step(1, 4, 32'h3C,  1, 8, 32'h88,   0, 0, 0, 0,       1, 1, 0, 0);
        idle(1, 1, 0, 0);
        clk_en_i = 1'b1;
        step(0, 0, 0,       0, 0, 0,        1, 14, 32'hE0, 1, 1, 1, 0, 0);
        idle(0, 1, 0, 0);

        // Reset mid-operation discards the buffered load
        step(1, 2, 32'h2A,  1, 15, 32'hF0,  1, 2, 32'h2A, 0,  0, 1, 0, 0);
        do_reset();
        idle(0, 1, 0, 0);

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of the integer register file between the execute-stage writeback and the load/store-queue writeback. EX writes always win. Colliding LSQ writes are held in a small FIFO and committed in order on free cycles. A starvation counter requests an upstream hold when loads wait too long. It sits between the ex stage / lsq and the register file, and it drives the load-scoreboard clear and forwarding paths.

## Interface
Parameters:
- DEPTH, 2: LSQ buffer entries; power of two, ≥2
- STARVE_MAX, 4: consecutive blocked cycles before a hold is requested; ≥1
- XLEN, `RV_XLEN: data width

Ports:
- clk_i  in  1  clock; all state on rising edge
- reset_i  in  1  synchronous, active-high reset
- clk_en_i  in  1  state update enable; when low, all state holds
- exs_wr_i  in  1  ex writeback request
- exs_addr_i  in  5  ex destination register
- exs_data_i  in  XLEN  ex writeback data
- lsq_wr_i  in  1  load writeback valid
- lsq_addr_i  in  5  load destination register
- lsq_data_i  in  XLEN  load data
- lsq_ready_o  out  1  buffer can accept a load writeback this cycle
- rf_wr_o  out  1  register file write strobe
- rf_addr_o  out  5  register file write address
- rf_data_o  out  XLEN  register file write data
- rf_src_lsq_o  out  1  current write is a load commit; drives the scoreboard clear
- exs_hold_o  out  1  registered request to suppress ex writebacks
- fifo_level_o  out  $clog2(DEPTH+1)  buffered entry count
- lsq_ovf_o  out  1  sticky flag: a load was presented while lsq_ready_o was low

## Operation
- Writes to x0 are discarded at the input: never committed, never buffered, and they do not count as requests.
- Port selection priority per cycle:
  1. EX write: committed, with rf_src_lsq_o=0.
  2. Otherwise, if the FIFO is non-empty: pop the head and commit it.
  3. Otherwise, an incoming LSQ write passes straight through with no buffering.
- An incoming LSQ write that is not committed that cycle is pushed. A simultaneous push and pop is allowed; the level is unchanged.
- Commit order of LSQ writes is strictly arrival order.
- lsq_ready_o = (level != DEPTH). It is computed from the current level only, so there is no ready-through-pop.
- An LSQ write while ready is low is dropped and sets lsq_ovf_o. lsq_ovf_o is cleared only by reset.
- Starvation counter:
  - Increments each enabled cycle in which an EX write occurs while the FIFO is non-empty.
  - Clears on any pop.
  - Saturates at STARVE_MAX.
- exs_hold_o is set on the edge where the counter reaches STARVE_MAX. It clears on the edge after the first pop.
- exs_hold_o is advisory: an EX write that arrives anyway still wins.
- Same-register ordering between EX and pending loads is guaranteed by the id-stage scoreboard and is not checked here.

## Timing
- Output port (rf_*) is combinational from the current inputs and the FIFO head, with zero latency. The register file samples on the next edge.
- Load latency:
  - 0 cycles when the buffer is empty and there is no EX write.
  - Otherwise, commits the first cycle it reaches the head with no EX write.
- Reset values: level 0, counter 0, exs_hold_o 0, lsq_ovf_o 0, lsq_ready_o 1. rf_wr_o follows its inputs, so it is 0 with idle inputs.
- Reset mid-operation discards all buffered loads. Upstream must re-issue or flush them.
- When clk_en_i is low, combinational outputs still reflect state, but no push, pop, counter or flag update occurs.
- Pointers wrap modulo DEPTH.

## Structure
- Shared package/defines: RV_XLEN and register-address width (5).
- Sub-module: regwb_fifo, a synchronous DEPTH×(5+XLEN) FIFO with push, pop, head, level and full.
- Top level holds the priority mux, starvation counter, hold register and overflow flag. Estimated 150–250 lines total.

## Test plan
- Idle reset: assert reset_i 2 cycles -> level 0, lsq_ready_o 1, exs_hold_o 0, lsq_ovf_o 0, rf_wr_o 0.
- Bypass: LSQ x5=0xA5 alone, empty buffer -> same cycle rf_wr_o 1, rf_addr_o 5, rf_data_o 0xA5, rf_src_lsq_o 1; level stays 0.
- Collision and order, DEPTH=2:
  - Cycle 0: EX x3 with LSQ x7.
  - Cycle 1: EX x4 with LSQ x8.
  - Then idle.
  - Required: EX commits in cycles 0–1; x7 commits at cycle 2, x8 at cycle 3; level goes 1, 2, 1, 0; lsq_ready_o is 0 during cycle 2.
- Overflow: fill 2 entries under continuous EX writes, then present LSQ x9 with ready low -> x9 never committed, lsq_ovf_o 1 and held until reset.
- Starvation, STARVE_MAX=4: buffer 1 load, then 4 further consecutive EX writes -> exs_hold_o rises after the 4th; drop EX -> pop on the next cycle, exs_hold_o 0 one edge later.
- x0 and clk_en: LSQ x0 write during an EX write -> level unchanged. Repeat the collision scenario with clk_en_i low -> level unchanged, no pop.
